// File: rtl/switch_pkg.sv
// Shared types and helpers for the 4-port switch scheduler.
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int SRC_W     = 2;

    typedef logic [1:0] port_idx_t;
    typedef logic [3:0] port_mask_t;

    function automatic port_idx_t onehot_to_idx(input port_mask_t oh);
        port_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) idx = idx | port_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter; pointer moves past the winner on each grant.
module rr_arbiter
    import switch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  port_mask_t req_i,
    output port_mask_t grant_o
);

    port_idx_t rr_q;
    port_idx_t rr_d;
    port_idx_t idx;
    logic      found;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_o = '0;
        rr_d    = rr_q;
        found   = 1'b0;
        idx     = '0;
        if (en_i) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = rr_q + port_idx_t'(k);
                if (!found && req_i[idx]) begin
                    found        = 1'b1;
                    grant_o[idx] = 1'b1;
                    rr_d         = idx + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end

endmodule

// File: rtl/switch_scheduler.sv
// Per-output round-robin scheduler with multicast tracking for the 4-port switch.
// Optional SWITCH_SCHED_STATS_EN adds saturating grant and drop counters.
module switch_scheduler
    import switch_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_target,
    output logic [NUM_PORTS-1:0]           in_pop,
    input  logic [NUM_PORTS-1:0]           out_ready,
    output logic [NUM_PORTS-1:0]           out_valid,
    output logic [NUM_PORTS*SRC_W-1:0]     out_src
`ifdef SWITCH_SCHED_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]        stat_grants,
    output logic [15:0]                    stat_drops
`endif
);

    port_mask_t                 served_q [NUM_PORTS];
    port_mask_t                 served_d [NUM_PORTS];
    port_mask_t                 pending  [NUM_PORTS];
    port_mask_t                 req      [NUM_PORTS];
    port_mask_t                 grant    [NUM_PORTS];
    port_mask_t                 granted  [NUM_PORTS];
    logic [NUM_PORTS-1:0]       zero_drop;
    logic [NUM_PORTS-1:0]       out_valid_q;
    logic [NUM_PORTS*SRC_W-1:0] out_src_q;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            pending[i] = in_valid[i] ? (in_target[NUM_PORTS*i +: NUM_PORTS] & ~served_q[i]) : '0;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) req[o][i] = pending[i][o];
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .clk    (clk),
            .rst    (rst),
            .en_i   (out_ready[o]),
            .req_i  (req[o]),
            .grant_o(grant[o])
        );
    end

    // A head retires once every still-pending target is granted in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) granted[i][o] = grant[o][i];
            zero_drop[i] = in_valid[i] && (in_target[NUM_PORTS*i +: NUM_PORTS] == '0);
            in_pop[i]    = !rst && (zero_drop[i] ||
                           ((pending[i] != '0) && ((pending[i] & ~granted[i]) == '0)));
            served_d[i]  = in_pop[i] ? '0 : (served_q[i] | granted[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: served is small control state and must be reset; a stale mask would skip targets.
            for (int i = 0; i < NUM_PORTS; i++) served_q[i] <= '0;
            out_valid_q <= '0;
            out_src_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) served_q[i] <= served_d[i];
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_valid_q[o] <= |grant[o];
                if (|grant[o]) out_src_q[SRC_W*o +: SRC_W] <= onehot_to_idx(grant[o]);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

`ifdef SWITCH_SCHED_STATS_EN
    logic [15:0] grant_cnt_q [NUM_PORTS];
    logic [15:0] drop_cnt_q;
    logic [2:0]  drop_num;
    logic [16:0] drop_sum;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_PORTS; i++) drop_num = drop_num + 3'(zero_drop[i]);
        drop_sum = {1'b0, drop_cnt_q} + 17'(drop_num);
        for (int o = 0; o < NUM_PORTS; o++) stat_grants[16*o +: 16] = grant_cnt_q[o];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) grant_cnt_q[o] <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if ((|grant[o]) && (grant_cnt_q[o] != 16'hFFFF)) grant_cnt_q[o] <= grant_cnt_q[o] + 16'd1;
            end
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign stat_drops = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_scheduler.sv
// Directed bench for switch_scheduler; expected deliveries queued per output and checked by a monitor.
module tb_switch_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_target;
    logic [3:0]  in_pop;
    logic [3:0]  out_ready;
    logic [3:0]  out_valid;
    logic [7:0]  out_src;
`ifdef SWITCH_SCHED_STATS_EN
    logic [63:0] stat_grants;
    logic [15:0] stat_drops;
`endif

    int checks     = 0;
    int failures   = 0;
    int deliveries = 0;
    int base;
    logic [1:0] exp_q [4][$];
    logic [1:0] mon_exp;

    switch_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_target  (in_target),
        .in_pop     (in_pop),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_src    (out_src)
`ifdef SWITCH_SCHED_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_drops (stat_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented output must match the oldest expected source for that port.
    always @(negedge clk) begin
        for (int o = 0; o < 4; o++) begin
            if (out_valid[o] === 1'b1) begin
                deliveries++;
                if (exp_q[o].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery out=%0d actual_src=%0d required=none", o, out_src[2*o +: 2]);
                end else begin
                    mon_exp = exp_q[o].pop_front();
                    check($sformatf("out%0d_src", o), 64'(out_src[2*o +: 2]), 64'(mon_exp));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_target = '0;
        out_ready = 4'b1111;
        #1;
        check("pop_forced_in_reset", 64'(in_pop), 64'h0);
        step();
        step();
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_out_src", 64'(out_src), 64'h0);

        // Idle
        rst      = 1'b0;
        in_valid = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("idle_pop", 64'(in_pop), 64'h0);
            check("idle_out_valid", 64'(out_valid), 64'h0);
            step();
        end
`ifdef SWITCH_SCHED_STATS_EN
        check("idle_stat_grants", stat_grants, 64'h0);
        check("idle_stat_drops", 64'(stat_drops), 64'h0);
`endif

        // Unicast: input 2 -> output 3
        base              = deliveries;
        in_valid          = 4'b0100;
        in_target[8 +: 4] = 4'b1000;
        exp_q[3].push_back(2'd2);
        #1;
        check("unicast_pop", 64'(in_pop), 64'h4);
        step();
        in_valid = '0;
        step();
        check("unicast_deliveries", 64'(deliveries - base), 64'd1);

        // Contention: every input targets output 0 continuously
        base      = deliveries;
        in_valid  = 4'b1111;
        in_target = 16'h1111;
        for (int k = 0; k < 8; k++) begin
            exp_q[0].push_back(2'(k % 4));
            #1;
            check($sformatf("contention_pop_%0d", k), 64'(in_pop), 64'(1 << (k % 4)));
            step();
        end
        in_valid = '0;
        step();
        check("contention_deliveries", 64'(deliveries - base), 64'd8);

        // Multicast with output 2 backpressured for 3 cycles
        base              = deliveries;
        in_valid          = 4'b0010;
        in_target         = '0;
        in_target[4 +: 4] = 4'b0110;
        out_ready         = 4'b1011;
        exp_q[1].push_back(2'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("mcast_hold_pop_%0d", k), 64'(in_pop), 64'h0);
            step();
        end
        out_ready = 4'b1111;
        exp_q[2].push_back(2'd1);
        #1;
        check("mcast_retire_pop", 64'(in_pop), 64'h2);
        step();
        in_valid = '0;
        step();
        step();
        check("mcast_deliveries", 64'(deliveries - base), 64'd2);

        // Zero-mask head is dropped without delivery
        base      = deliveries;
        in_valid  = 4'b1000;
        in_target = '0;
        #1;
        check("zero_mask_pop", 64'(in_pop), 64'h8);
        step();
        in_valid = '0;
        step();
        check("zero_mask_deliveries", 64'(deliveries - base), 64'd0);
`ifdef SWITCH_SCHED_STATS_EN
        check("stat_drops_one", 64'(stat_drops), 64'd1);
        check("stat_grants_pre_reset", stat_grants, {16'd1, 16'd1, 16'd1, 16'd8});
`endif

        // Reset in the middle of a broadcast
        base              = deliveries;
        in_valid          = 4'b0001;
        in_target[0 +: 4] = 4'b1111;
        out_ready         = 4'b0001;
        exp_q[0].push_back(2'd0);
        #1;
        check("bcast_partial_pop", 64'(in_pop), 64'h0);
        step();
        rst = 1'b1;
        #1;
        check("bcast_pop_in_reset", 64'(in_pop), 64'h0);
        step();
        rst       = 1'b0;
        out_ready = 4'b1111;
        for (int o = 0; o < 4; o++) exp_q[o].push_back(2'd0);
        #1;
        check("bcast_retire_pop", 64'(in_pop), 64'h1);
        step();
        in_valid = '0;
        #1;
        check("bcast_no_second_pop", 64'(in_pop), 64'h0);
        step();
        step();
        check("bcast_deliveries", 64'(deliveries - base), 64'd5);
`ifdef SWITCH_SCHED_STATS_EN
        check("stat_grants_post_reset", stat_grants, {16'd1, 16'd1, 16'd1, 16'd1});
        check("stat_drops_post_reset", 64'(stat_drops), 64'd0);
`endif

        for (int o = 0; o < 4; o++) begin
            check($sformatf("out%0d_queue_drained", o), 64'(exp_q[o].size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
